// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and defaults for the I/D cache memory arbiter
package cache_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // One in-flight memory read: who it belongs to and whether it ends the block
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   last;
  } tag_t;

  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_MEM_LATENCY = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side signal bundle for the arbiter
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic [DATA_W-1:0] d_data;
  logic              d_data_valid;
  logic              d_done;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic              i_done;

  logic [ADDR_W-1:0] memory_address;
  logic              memory_enable;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              spurious_valid;

  // Arbiter side
  modport master (
    input  d_req, d_addr, i_req, i_addr, memory_data, memory_data_valid,
    output d_gnt, d_data, d_data_valid, d_done,
    output i_gnt, i_data, i_data_valid, i_done,
    output memory_address, memory_enable, spurious_valid
  );

  // Environment side: miss handlers and memory
  modport slave (
    output d_req, d_addr, i_req, i_addr, memory_data, memory_data_valid,
    input  d_gnt, d_data, d_data_valid, d_done,
    input  i_gnt, i_data, i_data_valid, i_done,
    input  memory_address, memory_enable, spurious_valid
  );

endinterface

// File: rtl/cache_mem_arbiter_tag_pipe.sv
// rtl/cache_mem_arbiter_tag_pipe.sv - owner tag delay line matched to memory read latency
module arb_tag_pipe
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  // Shift by one stage every cycle; stage 0 takes the tag of the read issued this cycle
  always_comb begin
    stage_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Clearing every stage drops all reads that were in flight at reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D miss burst arbiter for one memory read port; CACHE_ARB_RR_EN selects round-robin ties
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GRD_W = $clog2(MEM_LATENCY + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [GRD_W-1:0]  GRD_INIT = GRD_W'(MEM_LATENCY);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              gnt_q, gnt_d;
  logic              d_busy_q, d_busy_d;
  logic              i_busy_q, i_busy_d;
  logic              spur_q, spur_d;
  logic [GRD_W-1:0]  guard_q, guard_d;
`ifdef CACHE_ARB_RR_EN
  owner_e            last_owner_q, last_owner_d;
`endif

  logic              d_elig, i_elig, d_pick;
  logic              last_issue, can_arb;
  logic              d_dv, i_dv;
  logic [DATA_W-1:0] rd_word;
  tag_t              tag_in, tag_tail;

  // Next-state: burst sequencing, arbitration, busy tracking and spurious detection.
  // A side stays busy from its grant until its last word returns, so a level
  // request still high during the data tail is not re-granted.
  // After reset the guard window lets reads issued before reset drain silently.
  always_comb begin
    d_elig = bus.d_req & ~d_busy_q;
    i_elig = bus.i_req & ~i_busy_q;
`ifdef CACHE_ARB_RR_EN
    d_pick = d_elig & (~i_elig | (last_owner_q == OWN_I));
    last_owner_d = last_owner_q;
`else
    d_pick = d_elig;
`endif
    last_issue = (state_q == BURST) && (cnt_q == CNT_LAST);
    can_arb    = (state_q == IDLE) || last_issue;

    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    gnt_d    = 1'b0;
    d_busy_d = d_busy_q & ~(tag_tail.valid & tag_tail.last & (tag_tail.owner == OWN_D));
    i_busy_d = i_busy_q & ~(tag_tail.valid & tag_tail.last & (tag_tail.owner == OWN_I));
    spur_d   = spur_q | (bus.memory_data_valid & ~tag_tail.valid & (guard_q == '0));
    guard_d  = (guard_q == '0) ? '0 : guard_q - GRD_W'(1);

    if (state_q == BURST) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_issue) state_d = IDLE;
    end

    // Grant from IDLE or straight out of the last issue cycle, so bursts abut
    if (can_arb && (d_elig || i_elig)) begin
      state_d = BURST;
      cnt_d   = '0;
      gnt_d   = 1'b1;
      if (d_pick) begin
        owner_d  = OWN_D;
        base_d   = bus.d_addr & ~BLK_MASK;
        d_busy_d = 1'b1;
      end else begin
        owner_d  = OWN_I;
        base_d   = bus.i_addr & ~BLK_MASK;
        i_busy_d = 1'b1;
      end
`ifdef CACHE_ARB_RR_EN
      last_owner_d = owner_d;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      cnt_q    <= '0;
      base_q   <= '0;
      gnt_q    <= 1'b0;
      d_busy_q <= 1'b0;
      i_busy_q <= 1'b0;
      spur_q   <= 1'b0;
      guard_q  <= GRD_INIT;
`ifdef CACHE_ARB_RR_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      gnt_q    <= gnt_d;
      d_busy_q <= d_busy_d;
      i_busy_q <= i_busy_d;
      spur_q   <= spur_d;
      guard_q  <= guard_d;
`ifdef CACHE_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Tag of the read issued this cycle
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == BURST);
    tag_in.owner = owner_q;
    tag_in.last  = last_issue;
  end

  arb_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  assign d_dv    = tag_tail.valid & bus.memory_data_valid & (tag_tail.owner == OWN_D);
  assign i_dv    = tag_tail.valid & bus.memory_data_valid & (tag_tail.owner == OWN_I);
  assign rd_word = bus.memory_data;

  assign bus.memory_enable  = (state_q == BURST);
  assign bus.memory_address = base_q + (ADDR_W'(cnt_q) << 1);
  assign bus.d_gnt          = gnt_q & (owner_q == OWN_D);
  assign bus.i_gnt          = gnt_q & (owner_q == OWN_I);
  assign bus.d_data         = rd_word;
  assign bus.i_data         = rd_word;
  assign bus.d_data_valid   = d_dv;
  assign bus.i_data_valid   = i_dv;
  assign bus.d_done         = d_dv & tag_tail.last;
  assign bus.i_done         = i_dv & tag_tail.last;
  assign bus.spurious_valid = spur_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .BURST_LEN(8), .MEM_LATENCY(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Fixed latency-4 memory: returns address ^ 16'h5A5A
  logic [3:0]  mv = 4'b0;
  logic [15:0] ma [4];
  logic        inject;

  always @(posedge clk) begin
    mv    <= {mv[2:0], bus.memory_enable};
    ma[0] <= bus.memory_address;
    ma[1] <= ma[0];
    ma[2] <= ma[1];
    ma[3] <= ma[2];
  end

  assign bus.memory_data_valid = mv[3] | inject;
  assign bus.memory_data       = ma[3] ^ 16'h5A5A;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // One requester alone; checks grant, issue addresses, returned data and done
  task automatic single_burst(input string nm, input bit side_d, input logic [15:0] addr,
                              input logic [15:0] base);
    logic [15:0] ea;
    logic        own_gnt, own_dv, oth_dv, own_done;
    logic [15:0] own_data;
    if (side_d) begin bus.d_req = 1'b1; bus.d_addr = addr; end
    else        begin bus.i_req = 1'b1; bus.i_addr = addr; end
    for (int c = 1; c <= 14; c++) begin
      step();
      own_gnt  = side_d ? bus.d_gnt : bus.i_gnt;
      own_dv   = side_d ? bus.d_data_valid : bus.i_data_valid;
      oth_dv   = side_d ? bus.i_data_valid : bus.d_data_valid;
      own_done = side_d ? bus.d_done : bus.i_done;
      own_data = side_d ? bus.d_data : bus.i_data;
      chk($sformatf("%s_gnt_c%0d", nm, c), own_gnt, c == 1);
      chk($sformatf("%s_en_c%0d", nm, c), bus.memory_enable, c <= 8);
      if (c <= 8) begin
        ea = base + 16'(2 * (c - 1));
        chk($sformatf("%s_addr_c%0d", nm, c), bus.memory_address, ea);
      end
      chk($sformatf("%s_dv_c%0d", nm, c), own_dv, (c >= 5) && (c <= 12));
      chk($sformatf("%s_other_dv_c%0d", nm, c), oth_dv, 0);
      if (c >= 5 && c <= 12) begin
        ea = (base + 16'(2 * (c - 5))) ^ 16'h5A5A;
        chk($sformatf("%s_data_c%0d", nm, c), own_data, ea);
      end
      chk($sformatf("%s_done_c%0d", nm, c), own_done, c == 12);
      if (c == 12) begin
        if (side_d) bus.d_req = 1'b0;
        else        bus.i_req = 1'b0;
      end
    end
  endtask

  initial begin : main
    logic [15:0] ea;
    logic [1:0]  exp_win;
    rst = 1'b0;
    inject = 1'b0;
    bus.d_req = 1'b0; bus.d_addr = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", bus.memory_enable, 0);
    chk("rst_addr", bus.memory_address, 0);
    chk("rst_dgnt", bus.d_gnt, 0);
    chk("rst_ignt", bus.i_gnt, 0);
    chk("rst_dv", {bus.d_data_valid, bus.i_data_valid}, 0);
    chk("rst_spur", bus.spurious_valid, 0);
    rst = 1'b1;
    step();

    // Single D block
    single_burst("t1", 1'b1, 16'h1234, 16'h1230);

    // Simultaneous requests: D first, I follows with no gap
    reset_pulse();
    bus.d_req = 1'b1; bus.d_addr = 16'h2000;
    bus.i_req = 1'b1; bus.i_addr = 16'h8008;
    for (int c = 1; c <= 22; c++) begin
      step();
      chk($sformatf("t2_dgnt_c%0d", c), bus.d_gnt, c == 1);
      chk($sformatf("t2_ignt_c%0d", c), bus.i_gnt, c == 9);
      chk($sformatf("t2_en_c%0d", c), bus.memory_enable, c <= 16);
      if (c <= 16) begin
        ea = (c <= 8) ? 16'h2000 + 16'(2 * (c - 1)) : 16'h8000 + 16'(2 * (c - 9));
        chk($sformatf("t2_addr_c%0d", c), bus.memory_address, ea);
      end
      chk($sformatf("t2_ddv_c%0d", c), bus.d_data_valid, (c >= 5) && (c <= 12));
      chk($sformatf("t2_idv_c%0d", c), bus.i_data_valid, (c >= 13) && (c <= 20));
      if (c >= 5 && c <= 12) begin
        ea = (16'h2000 + 16'(2 * (c - 5))) ^ 16'h5A5A;
        chk($sformatf("t2_ddata_c%0d", c), bus.d_data, ea);
      end
      if (c >= 13 && c <= 20) begin
        ea = (16'h8000 + 16'(2 * (c - 13))) ^ 16'h5A5A;
        chk($sformatf("t2_idata_c%0d", c), bus.i_data, ea);
      end
      chk($sformatf("t2_ddone_c%0d", c), bus.d_done, c == 12);
      chk($sformatf("t2_idone_c%0d", c), bus.i_done, c == 20);
      if (c == 12) bus.d_req = 1'b0;
      if (c == 20) bus.i_req = 1'b0;
    end

    // I block at the top of the address space
    single_burst("t4", 1'b0, 16'hFFFE, 16'hFFF0);

    // Reset in cycle 6 of a D burst
    bus.d_req = 1'b1; bus.d_addr = 16'h4000;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("t5_en_c%0d", c), bus.memory_enable, 1);
    end
    rst = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk("t5_rst_en", bus.memory_enable, 0);
    chk("t5_rst_addr", bus.memory_address, 0);
    chk("t5_rst_dv", bus.d_data_valid, 0);
    chk("t5_rst_spur", bus.spurious_valid, 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("t5_post_en_%0d", c), bus.memory_enable, 0);
      chk($sformatf("t5_post_dv_%0d", c), {bus.d_data_valid, bus.i_data_valid}, 0);
      chk($sformatf("t5_post_spur_%0d", c), bus.spurious_valid, 0);
    end
    single_burst("t5b", 1'b1, 16'h4000, 16'h4000);

    // Stray memory valid while idle
    inject = 1'b1;
    #1;
    chk("t6_dv", {bus.d_data_valid, bus.i_data_valid}, 0);
    step();
    inject = 1'b0;
    chk("t6_spur_set", bus.spurious_valid, 1);
    repeat (5) step();
    chk("t6_spur_held", bus.spurious_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_spur_clr", bus.spurious_valid, 0);
    step();
    rst = 1'b1;
    step();

    // Three tie rounds; losing request withdrawn after the first grant
    for (int r = 0; r < 3; r++) begin
      bus.d_req = 1'b1; bus.d_addr = 16'h0100;
      bus.i_req = 1'b1; bus.i_addr = 16'h0200;
      step();
`ifdef CACHE_ARB_RR_EN
      exp_win = (r == 1) ? 2'b01 : 2'b10;
`else
      exp_win = 2'b10;
`endif
      chk($sformatf("t3_win_r%0d", r), {bus.d_gnt, bus.i_gnt}, exp_win);
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
      repeat (16) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
